// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: shares one HD44780-style LCD write bus among three
// requesters. Requests are granted round-robin. Each granted byte is driven
// through setup, enable pulse, hold and execution-wait phases. A single
// 17-bit down-counter times every phase. All outputs are registered.
module lcd_bus_arbiter #(
  parameter int T_SETUP = 2,
  parameter int T_EN    = 25,
  parameter int T_HOLD  = 2,
  parameter int T_EXEC  = 2500,
  parameter int T_LONG  = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready_i,
  input  logic [2:0]  req,
  input  logic [2:0]  req_rs,
  input  logic [23:0] req_data,
  output logic [2:0]  ack,
  output logic [2:0]  done,
  output logic        busy,
  output logic        rs,
  output logic        rw,
  output logic [7:0]  data,
  output logic        enable
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_EXEC  = 3'd4
  } state_t;

  // Counter reload values: a phase of N cycles loads N-1 and ends when the counter reaches 0.
  localparam logic [16:0] CNT_SETUP = 17'(T_SETUP - 1);
  localparam logic [16:0] CNT_EN    = 17'(T_EN - 1);
  localparam logic [16:0] CNT_HOLD  = 17'(T_HOLD - 1);
  localparam logic [16:0] CNT_EXEC  = 17'(T_EXEC - 1);
  localparam logic [16:0] CNT_LONG  = 17'(T_LONG - 1);

  state_t      state, state_nxt;
  logic [16:0] cnt, cnt_nxt;
  logic [1:0]  last, last_nxt;
  logic [1:0]  win;
  logic [1:0]  cand;
  logic        found;
  logic        grant;
  logic        is_long;
  logic        phase_end;

  logic [2:0]  ack_nxt;
  logic [2:0]  done_nxt;
  logic        busy_nxt;
  logic        enable_nxt;
  logic        rs_nxt;
  logic [7:0]  data_nxt;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [7:0] sel_byte(input logic [23:0] bytes, input logic [1:0] i);
    case (i)
      2'd0:    return bytes[7:0];
      2'd1:    return bytes[15:8];
      default: return bytes[23:16];
    endcase
  endfunction

  function automatic logic [2:0] one_hot(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  assign rw        = 1'b0;
  assign phase_end = (cnt == 17'd0);

  // Clear (0x01) and return-home (0x02/0x03) commands need the long execution wait.
  assign is_long = !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));

  // Round-robin search starting one past the last winner.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    cand  = next_idx(last);
    for (int i = 0; i < 3; i++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
      cand = next_idx(cand);
    end
  end

  assign grant = (state == S_IDLE) && ready_i && found;

  // State register: phase, phase counter and last winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 17'd0;
      last  <= 2'd2;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  // Next-state logic: each phase reloads the counter for the one that follows.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    case (state)
      S_IDLE: begin
        if (grant) begin
          state_nxt = S_SETUP;
          cnt_nxt   = CNT_SETUP;
          last_nxt  = win;
        end
      end
      S_SETUP: begin
        if (phase_end) begin
          state_nxt = S_PULSE;
          cnt_nxt   = CNT_EN;
        end else begin
          cnt_nxt = cnt - 17'd1;
        end
      end
      S_PULSE: begin
        if (phase_end) begin
          state_nxt = S_HOLD;
          cnt_nxt   = CNT_HOLD;
        end else begin
          cnt_nxt = cnt - 17'd1;
        end
      end
      S_HOLD: begin
        if (phase_end) begin
          state_nxt = S_EXEC;
          cnt_nxt   = is_long ? CNT_LONG : CNT_EXEC;
        end else begin
          cnt_nxt = cnt - 17'd1;
        end
      end
      S_EXEC: begin
        if (phase_end) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 17'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 17'd0;
      end
    endcase
  end

  // Output logic: values the output flops take at the next edge, derived from the next state.
  always_comb begin
    ack_nxt    = grant ? one_hot(win) : 3'b000;
    done_nxt   = ((state == S_EXEC) && phase_end) ? one_hot(last) : 3'b000;
    busy_nxt   = (state_nxt != S_IDLE);
    enable_nxt = (state_nxt == S_PULSE);
    rs_nxt     = grant ? req_rs[win] : rs;
    data_nxt   = grant ? sel_byte(req_data, win) : data;
  end

  // Output registers keep enable glitch-free and hold rs/data until the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack    <= 3'b000;
      done   <= 3'b000;
      busy   <= 1'b0;
      enable <= 1'b0;
      rs     <= 1'b0;
      data   <= 8'h00;
    end else begin
      ack    <= ack_nxt;
      done   <= done_nxt;
      busy   <= busy_nxt;
      enable <= enable_nxt;
      rs     <= rs_nxt;
      data   <= data_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter, using shortened phase timings.
module tb_lcd_bus_arbiter;

  localparam int P_SETUP = 2;
  localparam int P_EN    = 5;
  localparam int P_HOLD  = 2;
  localparam int P_EXEC  = 20;
  localparam int P_LONG  = 60;
  // ack cycle to done cycle distance
  localparam int LAT_N = P_SETUP + P_EN + P_HOLD + P_EXEC;   // 29
  localparam int LAT_L = P_SETUP + P_EN + P_HOLD + P_LONG;   // 69

  logic        clk = 1'b0;
  logic        rst;
  logic        ready_i;
  logic [2:0]  req;
  logic [2:0]  req_rs;
  logic [23:0] req_data;
  logic [2:0]  ack;
  logic [2:0]  done;
  logic        busy;
  logic        rs;
  logic        rw;
  logic [7:0]  data;
  logic        enable;

  int n_assert = 0;
  int n_fail   = 0;

  lcd_bus_arbiter #(
    .T_SETUP(P_SETUP), .T_EN(P_EN), .T_HOLD(P_HOLD),
    .T_EXEC(P_EXEC), .T_LONG(P_LONG)
  ) dut (
    .clk(clk), .rst(rst), .ready_i(ready_i), .req(req), .req_rs(req_rs),
    .req_data(req_data), .ack(ack), .done(done), .busy(busy), .rs(rs),
    .rw(rw), .data(data), .enable(enable)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in the ack cycle; runs until done (bounded) and checks the phase timing.
  task automatic measure(input string tag, input logic [2:0] exp_done, input int exp_lat,
                         input logic exp_rs, input logic [7:0] exp_data, input int drop_at);
    int k, en_first, en_cnt, bsy_lo;
    k = 0; en_first = -1; en_cnt = 0; bsy_lo = 0;
    while (k < 200) begin
      tick();
      k++;
      if (k == drop_at) ready_i = 1'b0;
      if (done !== 3'b000) break;
      if (enable === 1'b1) begin
        if (en_first < 0) en_first = k;
        en_cnt++;
      end
      if (busy !== 1'b1) bsy_lo++;
    end
    chk({tag, "_done"}, {29'd0, done}, {29'd0, exp_done});
    chk({tag, "_lat"}, k, exp_lat);
    chk({tag, "_en_first"}, en_first, P_SETUP);
    chk({tag, "_en_width"}, en_cnt, P_EN);
    chk({tag, "_busy_gap"}, bsy_lo, 0);
    chk({tag, "_busy_idle"}, {31'd0, busy}, 0);
    chk({tag, "_rs_kept"}, {31'd0, rs}, {31'd0, exp_rs});
    chk({tag, "_data_kept"}, {24'd0, data}, {24'd0, exp_data});
  endtask

  initial begin
    int cnt_bad;
    logic [2:0] exp_ack;

    // 1. Reset values with all requests pending
    rst = 1'b0; ready_i = 1'b1; req = 3'b111; req_rs = 3'b000; req_data = 24'h0;
    repeat (3) tick();
    chk("rst_ack", {29'd0, ack}, 0);
    chk("rst_done", {29'd0, done}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_enable", {31'd0, enable}, 0);
    chk("rst_rs", {31'd0, rs}, 0);
    chk("rst_rw", {31'd0, rw}, 0);
    chk("rst_data", {24'd0, data}, 0);
    rst = 1'b1;
    tick();
    chk("rel_ack", {29'd0, ack}, 32'h1);
    chk("rel_busy", {31'd0, busy}, 1);
    req = 3'b000;
    measure("t1", 3'b001, LAT_N, 1'b0, 8'h00, -1);

    // 2. Single data write from requester 1
    req = 3'b010; req_rs = 3'b010; req_data = 24'h004100;
    tick();
    chk("t2_ack", {29'd0, ack}, 32'h2);
    chk("t2_rs", {31'd0, rs}, 1);
    chk("t2_data", {24'd0, data}, 32'h41);
    chk("t2_enable", {31'd0, enable}, 0);
    req = 3'b000; req_data = 24'hFFFFFF; req_rs = 3'b000;  // changes after ack ignored
    measure("t2", 3'b010, LAT_N, 1'b1, 8'h41, -1);

    // 3. Long-wait commands versus normal ones
    req = 3'b001; req_rs = 3'b000; req_data = 24'h000001;
    tick(); chk("t3a_ack", {29'd0, ack}, 32'h1); req = 3'b000;
    measure("t3a", 3'b001, LAT_L, 1'b0, 8'h01, -1);
    req = 3'b001; req_data = 24'h000038;
    tick(); chk("t3b_ack", {29'd0, ack}, 32'h1); req = 3'b000;
    measure("t3b", 3'b001, LAT_N, 1'b0, 8'h38, -1);
    req = 3'b001; req_data = 24'h000003;
    tick(); req = 3'b000;
    measure("t3c", 3'b001, LAT_L, 1'b0, 8'h03, -1);
    req = 3'b001; req_data = 24'h000004;
    tick(); req = 3'b000;
    measure("t3d", 3'b001, LAT_N, 1'b0, 8'h04, -1);
    req = 3'b001; req_rs = 3'b001; req_data = 24'h000001;
    tick(); req = 3'b000;
    measure("t3e", 3'b001, LAT_N, 1'b1, 8'h01, -1);

    // 4. Round-robin fairness from a fresh reset
    tick();
    rst = 1'b0; req_rs = 3'b000; req_data = 24'h333231;
    repeat (2) tick();
    req = 3'b111; rst = 1'b1;
    tick();
    for (int t = 0; t < 6; t++) begin
      exp_ack = 3'b001 << (t % 3);
      chk($sformatf("t4_ack%0d", t), {29'd0, ack}, {29'd0, exp_ack});
      if (t == 5) req = 3'b000;
      measure($sformatf("t4_%0d", t), exp_ack, LAT_N, 1'b0, 8'h31 + 8'(t % 3), -1);
      if (t < 5) tick();
    end

    // 5. ready_i gating
    ready_i = 1'b0; req = 3'b100;
    cnt_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (ack !== 3'b000 || busy !== 1'b0) cnt_bad++;
    end
    chk("t5_no_grant", cnt_bad, 0);
    ready_i = 1'b1;
    tick();
    chk("t5_ack", {29'd0, ack}, 32'h4);
    req = 3'b000;
    measure("t5", 3'b100, LAT_N, 1'b0, 8'h33, 3);
    req = 3'b100;
    cnt_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack !== 3'b000) cnt_bad++;
    end
    chk("t5_still_gated", cnt_bad, 0);

    // 6. Reset in the middle of the enable pulse
    req = 3'b010; ready_i = 1'b1;
    tick();
    chk("t6_ack", {29'd0, ack}, 32'h2);
    req = 3'b000;
    repeat (3) tick();
    chk("t6_enable_on", {31'd0, enable}, 1);
    rst = 1'b0;
    #1;
    chk("t6_enable_off", {31'd0, enable}, 0);
    chk("t6_busy_off", {31'd0, busy}, 0);
    chk("t6_data_off", {24'd0, data}, 0);
    cnt_bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done !== 3'b000 || ack !== 3'b000) cnt_bad++;
    end
    chk("t6_quiet", cnt_bad, 0);
    req = 3'b011; rst = 1'b1;
    tick();
    chk("t6_regrant", {29'd0, ack}, 32'h1);
    req = 3'b000;
    measure("t6", 3'b001, LAT_N, 1'b0, 8'h31, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
